// File: rtl/fifo8x9_ctrl.sv
// Driver-side controller for the 8x9 pointer FIFO storage: valid/ready ports,
// occupancy tracking, pointer wrap by clear. Optional FIFO8X9_CTRL_ALMOST_FULL_EN.
module fifo8x9_ctrl #(
  parameter int DEPTH    = 8,
  parameter int DW       = 9,
  parameter int AF_LEVEL = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DW-1:0]             s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DW-1:0]             m_data,
  output logic                      fifo_wren,
  output logic                      fifo_wrinc,
  output logic                      fifo_wrptrclr,
  output logic [DW-1:0]             fifo_din,
  output logic                      fifo_rden,
  output logic                      fifo_rdinc,
  output logic                      fifo_rdptrclr,
  input  logic [DW-1:0]             fifo_dout,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_EMPTY = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  generate
    if (DEPTH != (1 << PW) || AF_LEVEL > DEPTH) begin : g_bad_cfg
      $error("fifo8x9_ctrl: DEPTH must be a power of 2 and AF_LEVEL <= DEPTH");
    end
  endgenerate

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          flush_eff, in_init, wr_acc, rd_iss, wr_last, rd_last;

  // Control pins stay quiet while reset is held, even though state reads INIT.
  assign flush_eff = flush && rst;
  assign in_init   = (state_q == S_INIT) && rst;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign s_ready = !full && (state_q != S_INIT) && !flush;
  assign wr_acc  = s_valid && s_ready;
  assign rd_iss  = !flush_eff && !empty &&
                   ((state_q == S_EMPTY) || ((state_q == S_HOLD) && m_ready));
  assign wr_last = (wr_idx_q == PW'(DEPTH - 1));
  assign rd_last = (rd_idx_q == PW'(DEPTH - 1));

  assign fifo_din      = s_data;
  assign fifo_wren     = wr_acc;
  assign fifo_wrinc    = wr_acc && !wr_last;
  assign fifo_wrptrclr = in_init || flush_eff || (wr_acc && wr_last);
  assign fifo_rden     = rd_iss;
  assign fifo_rdinc    = rd_iss && !rd_last;
  assign fifo_rdptrclr = in_init || flush_eff || (rd_iss && rd_last);

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

`ifdef FIFO8X9_CTRL_ALMOST_FULL_EN
  assign almost_full = (count_q >= CW'(AF_LEVEL));
`else
  assign almost_full = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    count_d   = count_q + CW'(wr_acc) - CW'(rd_iss);
    wr_idx_d  = wr_acc ? (wr_last ? '0 : wr_idx_q + PW'(1)) : wr_idx_q;
    rd_idx_d  = rd_iss ? (rd_last ? '0 : rd_idx_q + PW'(1)) : rd_idx_q;
    case (state_q)
      S_INIT:  state_d = S_EMPTY;
      S_EMPTY: if (rd_iss) state_d = S_FETCH;
      S_FETCH: begin
        state_d   = S_HOLD;
        m_valid_d = 1'b1;
        m_data_d  = fifo_dout;
      end
      default: if (m_ready) begin
        m_valid_d = 1'b0;
        state_d   = rd_iss ? S_FETCH : S_EMPTY;
      end
    endcase
    // Flush drops everything, including a word still in flight from storage.
    if (flush) begin
      state_d   = S_EMPTY;
      m_valid_d = 1'b0;
      count_d   = '0;
      wr_idx_d  = '0;
      rd_idx_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_INIT;
      count_q   <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end
endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// Bench for fifo8x9_ctrl: vector table plus hand sequences, behavioural storage
// model, and a data scoreboard on the consumer port.
module tb_fifo8x9_ctrl;
  localparam int DEPTH = 8;
  localparam int DW    = 9;
`ifdef FIFO8X9_CTRL_ALMOST_FULL_EN
  localparam logic AF_ON = 1'b1;
`else
  localparam logic AF_ON = 1'b0;
`endif

  logic clk = 0, rst = 0, flush = 0, s_valid = 0, m_ready = 0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, m_valid, full, empty, almost_full;
  logic fifo_wren, fifo_wrinc, fifo_wrptrclr, fifo_rden, fifo_rdinc, fifo_rdptrclr;
  logic [DW-1:0] m_data, fifo_din, fifo_dout;
  logic [3:0] count;
  logic [5:0] ctrl;

  int checks = 0, errors = 0, nrd = 0;
  logic [DW-1:0] sb[$];

  fifo8x9_ctrl #(.DEPTH(DEPTH), .DW(DW), .AF_LEVEL(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .fifo_wren(fifo_wren), .fifo_wrinc(fifo_wrinc), .fifo_wrptrclr(fifo_wrptrclr),
    .fifo_din(fifo_din), .fifo_rden(fifo_rden), .fifo_rdinc(fifo_rdinc),
    .fifo_rdptrclr(fifo_rdptrclr), .fifo_dout(fifo_dout),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full)
  );

  always #5 clk = ~clk;
  assign ctrl = {fifo_wren, fifo_wrinc, fifo_wrptrclr, fifo_rden, fifo_rdinc, fifo_rdptrclr};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sb_pop(input string nm);
    if (sb.size() == 0) chk({nm, " sb_empty"}, 32'd1, 32'd0);
    else chk({nm, " m_data"}, 32'(m_data), 32'(sb.pop_front()));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Storage block model: pointers must never leave 0..DEPTH-1.
  logic [DW-1:0] mem [DEPTH];
  logic [3:0] wp = 0, rp = 0;
  logic [DW-1:0] dq = '0;
  logic dv = 0;
  assign fifo_dout = dv ? dq : 'z;

  always @(posedge clk) begin
    if (fifo_wren) begin
      chk("wr_ptr_range", 32'(wp < DEPTH), 32'd1);
      if (wp < DEPTH) mem[wp[2:0]] <= fifo_din;
    end
    if (fifo_rden) begin
      chk("rd_ptr_range", 32'(rp < DEPTH), 32'd1);
      if (rp < DEPTH) dq <= mem[rp[2:0]];
      nrd = nrd + 1;
      if (nrd == 8) chk("rd8_inc_clr", 32'({fifo_rdinc, fifo_rdptrclr}), 32'b01);
    end
    dv <= fifo_rden;
    if (fifo_wrptrclr) wp <= 0; else if (fifo_wrinc) wp <= wp + 1;
    if (fifo_rdptrclr) rp <= 0; else if (fifo_rdinc) rp <= rp + 1;
  end

  typedef struct {
    logic sv; logic [DW-1:0] sd; logic mr; logic fl;
    logic srdy; logic [5:0] ctl; logic [3:0] cnt; logic mv;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int popped, seen;
    // ctl = {wren, wrinc, wrclr, rden, rdinc, rdclr}
    tbl[0]  = '{1'b1, 9'h0AA, 1'b0, 1'b0, 1'b0, 6'b001001, 4'd0, 1'b0};
    tbl[1]  = '{1'b1, 9'h101, 1'b0, 1'b0, 1'b1, 6'b110000, 4'd0, 1'b0};
    tbl[2]  = '{1'b1, 9'h102, 1'b0, 1'b0, 1'b1, 6'b110110, 4'd1, 1'b0};
    tbl[3]  = '{1'b1, 9'h103, 1'b0, 1'b0, 1'b1, 6'b110000, 4'd1, 1'b0};
    tbl[4]  = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 6'b000000, 4'd2, 1'b1};
    tbl[5]  = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 6'b000110, 4'd2, 1'b1};
    tbl[6]  = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 6'b000000, 4'd1, 1'b0};
    tbl[7]  = '{1'b1, 9'h104, 1'b0, 1'b0, 1'b1, 6'b110000, 4'd1, 1'b1};
    tbl[8]  = '{1'b1, 9'h105, 1'b1, 1'b0, 1'b1, 6'b110110, 4'd2, 1'b1};
    tbl[9]  = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 6'b000000, 4'd2, 1'b0};
    tbl[10] = '{1'b1, 9'h106, 1'b0, 1'b1, 1'b0, 6'b001001, 4'd2, 1'b1};
    tbl[11] = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 6'b000000, 4'd0, 1'b0};

    // Reset held: outputs quiet even with flush/s_valid asserted.
    s_valid = 1; flush = 1;
    @(negedge clk);
    chk("rst ctrl", 32'(ctrl), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst m_valid", 32'(m_valid), 32'd0);
    chk("rst m_data", 32'(m_data), 32'd0);
    chk("rst s_ready", 32'(s_ready), 32'd0);
    s_valid = 0; flush = 0;
    @(posedge clk); #1 rst = 1;

    for (int i = 0; i < 12; i++) begin
      s_valid = tbl[i].sv; s_data = tbl[i].sd; m_ready = tbl[i].mr; flush = tbl[i].fl;
      @(negedge clk);
      chk($sformatf("v%0d s_ready", i), 32'(s_ready), 32'(tbl[i].srdy));
      chk($sformatf("v%0d ctrl", i), 32'(ctrl), 32'(tbl[i].ctl));
      chk($sformatf("v%0d count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d m_valid", i), 32'(m_valid), 32'(tbl[i].mv));
      if (tbl[i].sv && tbl[i].srdy) sb.push_back(tbl[i].sd);
      if (tbl[i].mv && tbl[i].mr && !tbl[i].fl) sb_pop($sformatf("v%0d", i));
      if (tbl[i].fl) sb.delete();
      tick();
    end
    flush = 0; s_valid = 0; m_ready = 0;

    // Reset mid-operation while a word sits in the output register.
    s_valid = 1; s_data = 9'h011; tick();
    s_data = 9'h012; tick();
    s_valid = 0; tick(); tick(); tick();
    @(negedge clk);
    chk("pre_rst m_data", 32'(m_data), 32'h011);
    #2 rst = 0; #1;
    chk("mid_rst count", 32'(count), 32'd0);
    chk("mid_rst m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst m_data", 32'(m_data), 32'd0);
    chk("mid_rst ctrl", 32'(ctrl), 32'd0);
    sb.delete();
    @(posedge clk); @(posedge clk); #1 rst = 1;
    s_valid = 1; s_data = 9'h0BB;
    @(negedge clk);
    chk("init s_ready", 32'(s_ready), 32'd0);
    chk("init ctrl", 32'(ctrl), 32'b001001);
    tick();
    s_valid = 0; nrd = 0;
    @(negedge clk);
    chk("post_init s_ready", 32'(s_ready), 32'd1);
    chk("post_init empty", 32'(empty), 32'd1);
    chk("post_init count", 32'(count), 32'd0);
    tick();

    // Fill: one word is prefetched into the output register, so nine fit.
    for (int k = 1; k <= 10; k++) begin
      s_valid = 1; s_data = 9'(k);
      @(negedge clk);
      chk($sformatf("fill%0d s_ready", k), 32'(s_ready), 32'(k <= 9));
      chk($sformatf("fill%0d wren", k), 32'(fifo_wren), 32'(k <= 9));
      if (k == 7) chk("fill7 wr", 32'(ctrl[5:3]), 32'b110);
      if (k == 8) chk("fill8 wr_wrap", 32'(ctrl[5:3]), 32'b101);
      if (k <= 9) sb.push_back(9'(k));
      tick();
    end
    s_valid = 0;
    @(negedge clk);
    chk("full count", 32'(count), 32'd8);
    chk("full flag", 32'(full), 32'd1);
    chk("full empty", 32'(empty), 32'd0);
    chk("full s_ready", 32'(s_ready), 32'd0);
    chk("full almost_full", 32'(almost_full), 32'(AF_ON));
    tick();

    // Drain in order.
    m_ready = 1; popped = 0;
    for (int c = 0; c < 60 && popped < 9; c++) begin
      @(negedge clk);
      if (m_valid) begin sb_pop("drain"); popped++; end
      tick();
    end
    chk("drain words", 32'(popped), 32'd9);
    @(negedge clk);
    chk("drain empty", 32'(empty), 32'd1);
    chk("drain almost_full", 32'(almost_full), 32'd0);
    tick();

    s_valid = 1; s_data = 9'h1AA; sb.push_back(9'h1AA); tick();
    s_valid = 0; seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (m_valid) begin sb_pop("1AA"); seen = 1; end
      tick();
    end
    chk("1AA seen", 32'(seen), 32'd1);

    // Concurrent write and read issue at count 4, then flush during FETCH.
    m_ready = 0;
    for (int k = 0; k < 5; k++) begin
      s_valid = 1; s_data = 9'h021 + 9'(k); sb.push_back(s_data); tick();
    end
    s_valid = 1; s_data = 9'h026; m_ready = 1;
    @(negedge clk);
    chk("sim count", 32'(count), 32'd4);
    chk("sim wren_rden", 32'({fifo_wren, fifo_rden}), 32'b11);
    sb_pop("sim");
    sb.push_back(9'h026);
    tick();
    s_valid = 1; s_data = 9'h027; flush = 1; m_ready = 0;
    @(negedge clk);
    chk("sim count_after", 32'(count), 32'd4);
    chk("flush s_ready", 32'(s_ready), 32'd0);
    chk("flush ctrl", 32'(ctrl), 32'b001001);
    sb.delete();
    tick();
    flush = 0; s_valid = 0; m_ready = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post_flush%0d m_valid", c), 32'(m_valid), 32'd0);
      chk($sformatf("post_flush%0d count", c), 32'(count), 32'd0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
